// File: rtl/shiftreg_piso_tx.sv
// Parallel-in / serial-out transmitter.
// A word is accepted with a valid/ready handshake and then shifted out on SDO,
// LSB first. One bit is consumed on each cycle where shift_en is high. A
// one-cycle done pulse follows the last bit. All outputs come from registers
// or are decoded from the registered FSM state only.
module shiftreg_piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             SDO,
  output logic             sdo_valid,
  output logic             done
);

  // The bit counter only has to reach WIDTH-1, which is the index of the last bit.
  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_p0, state_nxt;
  logic [WIDTH-1:0] shreg_p0, shreg_nxt;
  logic [CNT_W-1:0] cnt_p0,   cnt_nxt;
  logic             done_p0,  done_nxt;

  // Registers for state, data and control. The reset clears the shift data too,
  // so SDO is defined as soon as clrb falls.
  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state_p0 <= IDLE;
      shreg_p0 <= '0;
      cnt_p0   <= '0;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      shreg_p0 <= shreg_nxt;
      cnt_p0   <= cnt_nxt;
      done_p0  <= done_nxt;
    end
  end

  // Next-state logic. Every register holds by default. In IDLE, shift_en has no
  // effect. In SHIFT, load_valid has no effect and nothing is queued.
  always_comb begin
    state_nxt = state_p0;
    shreg_nxt = shreg_p0;
    cnt_nxt   = cnt_p0;
    done_nxt  = 1'b0;
    case (state_p0)
      IDLE: begin
        if (load_valid) begin
          state_nxt = SHIFT;
          shreg_nxt = load_data;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_p0 == CNT_LAST) begin
            // The last bit is consumed. The shift register is left as it is
            // because SDO is forced to 0 in IDLE anyway.
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            shreg_nxt = {1'b0, shreg_p0[WIDTH-1:1]};
            cnt_nxt   = cnt_p0 + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode. This uses only the registered state, so there is no path
  // from any input to any output.
  always_comb begin
    load_ready = (state_p0 == IDLE);
    sdo_valid  = (state_p0 == SHIFT);
    SDO        = (state_p0 == SHIFT) & shreg_p0[0];
    done       = done_p0;
  end

endmodule
